// File: rtl/waterloo_text_sequencer.sv
// Frame-synchronous animation controller for the "WATERLOO ENGINE" overlay: typewriter
// reveal, hold, blink, blank, loop. Every output is registered and moves only on a frame tick.
module waterloo_text_sequencer #(
  parameter int unsigned REVEAL_FRAMES = 8,
  parameter int unsigned HOLD_FRAMES   = 120,
  parameter int unsigned BLINK_FRAMES  = 16,
  parameter int unsigned BLINK_COUNT   = 3,
  parameter int unsigned OFF_FRAMES    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        enable,
  input  logic        restart,
  output logic [11:0] char_mask,
  output logic        text_visible,
  output logic [2:0]  phase,
  output logic        loop_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REVEAL = 3'd1,
    HOLD   = 3'd2,
    BLINK  = 3'd3,
    OFF    = 3'd4
  } state_t;

  localparam logic [7:0]  REVEAL_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0]  OFF_LAST    = 8'(OFF_FRAMES - 1);
  // At BLINK_COUNT=256 this wraps to 0, matching half_cnt wrapping on its 512th increment.
  localparam logic [8:0]  HALF_TARGET = 9'(2 * BLINK_COUNT);
  localparam logic [11:0] MASK_FIRST  = 12'h001;
  localparam logic [11:0] MASK_FULL   = '1;

  state_t      state;
  state_t      state_d;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_cnt_d;
  logic [7:0]  phase_last;
  logic [8:0]  half_cnt;
  logic [8:0]  half_cnt_d;
  logic [8:0]  half_inc;
  logic [11:0] char_mask_d;
  logic        text_visible_d;
  logic        loop_done_d;
  logic        restart_pend;
  logic        restart_pend_d;
  logic        frame_start_q;
  logic        tick;
  logic        phase_event;

  assign tick     = frame_start & ~frame_start_q;
  assign half_inc = half_cnt + 9'd1;
  assign phase    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      half_cnt      <= '0;
      char_mask     <= '0;
      text_visible  <= 1'b0;
      loop_done     <= 1'b0;
      restart_pend  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state         <= state_d;
      frame_cnt     <= frame_cnt_d;
      half_cnt      <= half_cnt_d;
      char_mask     <= char_mask_d;
      text_visible  <= text_visible_d;
      loop_done     <= loop_done_d;
      restart_pend  <= restart_pend_d;
      frame_start_q <= frame_start;
    end
  end

  always_comb begin
    phase_last = '0;
    case (state)
      REVEAL:  phase_last = REVEAL_LAST;
      HOLD:    phase_last = HOLD_LAST;
      BLINK:   phase_last = BLINK_LAST;
      OFF:     phase_last = OFF_LAST;
      default: phase_last = '0;
    endcase
  end

  assign phase_event = (frame_cnt == phase_last);

  always_comb begin
    state_d        = state;
    frame_cnt_d    = frame_cnt;
    half_cnt_d     = half_cnt;
    char_mask_d    = char_mask;
    text_visible_d = text_visible;
    loop_done_d    = 1'b0;
    restart_pend_d = restart_pend | restart;

    if (tick) begin
      // A restart arriving on the tick cycle itself is consumed by this tick.
      restart_pend_d = 1'b0;
      if (!enable) begin
        state_d        = IDLE;
        char_mask_d    = '0;
        text_visible_d = 1'b0;
      end else if (restart_pend || restart || (state == IDLE)) begin
        state_d        = REVEAL;
        char_mask_d    = MASK_FIRST;
        text_visible_d = 1'b1;
        frame_cnt_d    = '0;
      end else begin
        frame_cnt_d = phase_event ? '0 : frame_cnt + 8'd1;
        if (phase_event) begin
          case (state)
            REVEAL: begin
              if (char_mask == MASK_FULL) begin
                state_d = HOLD;
              end else begin
                char_mask_d = {char_mask[10:0], 1'b1};
              end
            end
            HOLD: begin
              state_d        = BLINK;
              text_visible_d = 1'b0;
              half_cnt_d     = '0;
            end
            BLINK: begin
              half_cnt_d = half_inc;
              if (half_inc == HALF_TARGET) begin
                state_d        = OFF;
                char_mask_d    = '0;
                text_visible_d = 1'b0;
              end else begin
                text_visible_d = ~text_visible;
              end
            end
            OFF: begin
              loop_done_d = 1'b1;
              if (enable) begin
                state_d        = REVEAL;
                char_mask_d    = MASK_FIRST;
                text_visible_d = 1'b1;
                frame_cnt_d    = '0;
              end else begin
                state_d        = IDLE;
                char_mask_d    = '0;
                text_visible_d = 1'b0;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_waterloo_text_sequencer.sv
// Bench for waterloo_text_sequencer: directed scenarios on a short-parameter instance,
// counter bounds on all-1 and all-256 instances, and a randomized run against a loop-position model.
module tb_waterloo_text_sequencer;

  localparam int unsigned S_R  = 2;
  localparam int unsigned S_H  = 3;
  localparam int unsigned S_BF = 2;
  localparam int unsigned S_BC = 2;
  localparam int unsigned S_OF = 2;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        enable;
  logic        restart;

  logic [11:0] char_mask,  mask_1,  mask_256;
  logic        text_visible, vis_1, vis_256;
  logic [2:0]  phase,      phase_1, phase_256;
  logic        loop_done,  ld_1,    ld_256;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position in the loop, counted in ticks since entering REVEAL.
  bit          m_idle;
  bit          m_pend;
  bit          m_ld;
  int unsigned m_p;

  waterloo_text_sequencer #(
    .REVEAL_FRAMES(S_R), .HOLD_FRAMES(S_H), .BLINK_FRAMES(S_BF),
    .BLINK_COUNT(S_BC), .OFF_FRAMES(S_OF)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable), .restart(restart),
    .char_mask(char_mask), .text_visible(text_visible), .phase(phase), .loop_done(loop_done)
  );

  waterloo_text_sequencer #(
    .REVEAL_FRAMES(1), .HOLD_FRAMES(1), .BLINK_FRAMES(1), .BLINK_COUNT(1), .OFF_FRAMES(1)
  ) dut_1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable), .restart(restart),
    .char_mask(mask_1), .text_visible(vis_1), .phase(phase_1), .loop_done(ld_1)
  );

  waterloo_text_sequencer #(
    .REVEAL_FRAMES(256), .HOLD_FRAMES(256), .BLINK_FRAMES(256), .BLINK_COUNT(256), .OFF_FRAMES(256)
  ) dut_256 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable), .restart(restart),
    .char_mask(mask_256), .text_visible(vis_256), .phase(phase_256), .loop_done(ld_256)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    rst = 1'b1; frame_start = 1'b0; enable = 1'b0; restart = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    m_idle = 1'b1; m_pend = 1'b0; m_ld = 1'b0; m_p = 0;
  endtask

  // One low cycle (plus gap), then a one-cycle strobe; returns #1 after the detecting edge.
  task automatic do_tick(input int unsigned gap);
    repeat (gap + 1) begin @(posedge clk); #1; end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic model_tick(input bit rs_now, input int unsigned r, input int unsigned h,
                            input int unsigned bf, input int unsigned bc, input int unsigned of);
    int unsigned len;
    len  = 12 * r + h + 2 * bc * bf + of;
    m_ld = 1'b0;
    if (!enable) begin
      m_idle = 1'b1;
    end else if (m_idle || m_pend || rs_now) begin
      m_idle = 1'b0;
      m_p    = 0;
    end else begin
      m_p++;
      if (m_p == len) begin
        m_p  = 0;
        m_ld = 1'b1;
      end
    end
    m_pend = 1'b0;
  endtask

  task automatic model_expect(input int unsigned r, input int unsigned h, input int unsigned bf,
                              input int unsigned bc, output logic [2:0] ph,
                              output logic [11:0] mk, output logic vs);
    int unsigned q;
    if (m_idle) begin
      ph = 3'd0; mk = 12'h000; vs = 1'b0;
    end else if (m_p < 12 * r) begin
      ph = 3'd1; mk = 12'((32'd1 << (m_p / r + 1)) - 32'd1); vs = 1'b1;
    end else if (m_p < 12 * r + h) begin
      ph = 3'd2; mk = 12'hFFF; vs = 1'b1;
    end else if (m_p < 12 * r + h + 2 * bc * bf) begin
      q  = m_p - 12 * r - h;
      ph = 3'd3; mk = 12'hFFF; vs = ((q / bf) % 2) == 1;
    end else begin
      ph = 3'd4; mk = 12'h000; vs = 1'b0;
    end
  endtask

  task automatic test_reset;
    apply_reset();
    n_tests++;
    if ({phase, char_mask, text_visible, loop_done} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_small: got ph=%0d mask=%h vis=%b ld=%b, want all zero",
               phase, char_mask, text_visible, loop_done);
    end
    n_tests++;
    if ({phase_1, mask_1, vis_1, ld_1, phase_256, mask_256, vis_256, ld_256} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_bounds: got ph1=%0d m1=%h ph256=%0d m256=%h, want all zero",
               phase_1, mask_1, phase_256, mask_256);
    end
    do_tick(0);
    n_tests++;
    if ({phase, char_mask, text_visible, loop_done} !== 17'h0) begin
      n_fail++;
      $display("FAIL disabled_tick: got ph=%0d mask=%h vis=%b, want idle", phase, char_mask, text_visible);
    end
  endtask

  task automatic test_sequence;
    logic [2:0]  eph;
    logic [11:0] emk;
    logic        evs, eld, chk;
    apply_reset();
    enable = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      do_tick(0);
      chk = 1'b1; eld = 1'b0;
      case (k)
        1, 2:   begin eph = 3'd1; emk = 12'h001; evs = 1'b1; end
        3:      begin eph = 3'd1; emk = 12'h003; evs = 1'b1; end
        23, 24: begin eph = 3'd1; emk = 12'hFFF; evs = 1'b1; end
        25, 27: begin eph = 3'd2; emk = 12'hFFF; evs = 1'b1; end
        28, 29: begin eph = 3'd3; emk = 12'hFFF; evs = 1'b0; end
        30, 34: begin eph = 3'd3; emk = 12'hFFF; evs = 1'b1; end
        32:     begin eph = 3'd3; emk = 12'hFFF; evs = 1'b0; end
        36, 37: begin eph = 3'd4; emk = 12'h000; evs = 1'b0; end
        38:     begin eph = 3'd1; emk = 12'h001; evs = 1'b1; eld = 1'b1; end
        default: begin chk = 1'b0; eph = 3'd0; emk = 12'h000; evs = 1'b0; end
      endcase
      if (chk) begin
        n_tests++;
        if ({phase, char_mask, text_visible, loop_done} !== {eph, emk, evs, eld}) begin
          n_fail++;
          $display("FAIL seq_tick%0d: got ph=%0d mask=%h vis=%b ld=%b, want ph=%0d mask=%h vis=%b ld=%b",
                   k, phase, char_mask, text_visible, loop_done, eph, emk, evs, eld);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if ({phase, char_mask, loop_done} !== {3'd1, 12'h001, 1'b0}) begin
      n_fail++;
      $display("FAIL loop_done_width: got ph=%0d mask=%h ld=%b, want ph=1 mask=001 ld=0",
               phase, char_mask, loop_done);
    end
  endtask

  task automatic test_long_strobe;
    apply_reset();
    enable = 1'b1;
    do_tick(0);
    do_tick(0);
    @(posedge clk); #1;
    frame_start = 1'b1;
    n_tests++;
    if (char_mask !== 12'h001) begin
      n_fail++;
      $display("FAIL strobe_pre_edge: got mask=%h, want 001", char_mask);
    end
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({phase, char_mask} !== {3'd1, 12'h003}) begin
        n_fail++;
        $display("FAIL strobe_hold_cycle%0d: got ph=%0d mask=%h, want ph=1 mask=003", c, phase, char_mask);
      end
    end
    frame_start = 1'b0;
    do_tick(0);
    do_tick(0);
    n_tests++;
    if (char_mask !== 12'h007) begin
      n_fail++;
      $display("FAIL strobe_after: got mask=%h, want 007", char_mask);
    end
  endtask

  task automatic test_enable_drop;
    apply_reset();
    enable = 1'b1;
    repeat (26) do_tick(0);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if ({phase, char_mask, text_visible} !== {3'd2, 12'hFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL enable_drop_between: got ph=%0d mask=%h vis=%b, want ph=2 mask=fff vis=1",
               phase, char_mask, text_visible);
    end
    do_tick(0);
    n_tests++;
    if ({phase, char_mask, text_visible} !== {3'd0, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL enable_drop_tick: got ph=%0d mask=%h vis=%b, want ph=0 mask=000 vis=0",
               phase, char_mask, text_visible);
    end
    enable = 1'b1;
    do_tick(2);
    n_tests++;
    if ({phase, char_mask, text_visible} !== {3'd1, 12'h001, 1'b1}) begin
      n_fail++;
      $display("FAIL enable_resume: got ph=%0d mask=%h vis=%b, want ph=1 mask=001 vis=1",
               phase, char_mask, text_visible);
    end
  endtask

  task automatic test_restart;
    apply_reset();
    enable = 1'b1;
    repeat (29) do_tick(0);
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({phase, char_mask, text_visible} !== {3'd3, 12'hFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_between: got ph=%0d mask=%h vis=%b, want ph=3 mask=fff vis=0",
               phase, char_mask, text_visible);
    end
    do_tick(0);
    n_tests++;
    if ({phase, char_mask, text_visible} !== {3'd1, 12'h001, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_taken: got ph=%0d mask=%h vis=%b, want ph=1 mask=001 vis=1",
               phase, char_mask, text_visible);
    end
    do_tick(0);
    do_tick(0);
    n_tests++;
    if (char_mask !== 12'h003) begin
      n_fail++;
      $display("FAIL restart_cleared: got mask=%h, want 003", char_mask);
    end
    do_tick(0);
    @(posedge clk); #1;
    frame_start = 1'b1;
    restart     = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    restart     = 1'b0;
    n_tests++;
    if ({phase, char_mask, text_visible} !== {3'd1, 12'h001, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_same_tick: got ph=%0d mask=%h vis=%b, want ph=1 mask=001 vis=1",
               phase, char_mask, text_visible);
    end
  endtask

  task automatic test_reset_collision;
    apply_reset();
    enable = 1'b1;
    repeat (4) do_tick(0);
    @(posedge clk); #1;
    frame_start = 1'b1;
    rst         = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    rst         = 1'b0;
    n_tests++;
    if ({phase, char_mask, text_visible, loop_done} !== 17'h0) begin
      n_fail++;
      $display("FAIL rst_over_tick: got ph=%0d mask=%h vis=%b ld=%b, want all zero",
               phase, char_mask, text_visible, loop_done);
    end
    do_tick(0);
    do_tick(0);
    n_tests++;
    if ({phase, char_mask} !== {3'd1, 12'h001}) begin
      n_fail++;
      $display("FAIL rst_recover: got ph=%0d mask=%h, want ph=1 mask=001", phase, char_mask);
    end
    do_tick(0);
    n_tests++;
    if (char_mask !== 12'h003) begin
      n_fail++;
      $display("FAIL rst_recover_shift: got mask=%h, want 003", char_mask);
    end
  endtask

  task automatic test_bounds;
    logic [2:0]  eph;
    logic [11:0] emk;
    logic        evs;
    apply_reset();
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      do_tick(0);
      model_tick(1'b0, 1, 1, 1, 1, 1);
      model_expect(1, 1, 1, 1, eph, emk, evs);
      n_tests++;
      if ({phase_1, mask_1, vis_1, ld_1} !== {eph, emk, evs, m_ld}) begin
        n_fail++;
        $display("FAIL bounds1_tick%0d: got ph=%0d mask=%h vis=%b ld=%b, want ph=%0d mask=%h vis=%b ld=%b",
                 k, phase_1, mask_1, vis_1, ld_1, eph, emk, evs, m_ld);
      end
    end
    apply_reset();
    enable = 1'b1;
    for (int k = 1; k <= 3073; k++) begin
      do_tick(0);
      model_tick(1'b0, 256, 256, 256, 256, 256);
      model_expect(256, 256, 256, 256, eph, emk, evs);
      n_tests++;
      if ({phase_256, mask_256, vis_256, ld_256} !== {eph, emk, evs, m_ld}) begin
        n_fail++;
        $display("FAIL bounds256_tick%0d: got ph=%0d mask=%h vis=%b ld=%b, want ph=%0d mask=%h vis=%b ld=%b",
                 k, phase_256, mask_256, vis_256, ld_256, eph, emk, evs, m_ld);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  eph;
    logic [11:0] emk;
    logic        evs;
    int unsigned gap, rmode;
    apply_reset();
    enable = 1'b1;
    for (int it = 0; it < 300; it++) begin
      enable = ($urandom_range(0, 59) != 0);
      gap    = $urandom_range(0, 3);
      rmode  = $urandom_range(0, 39);
      for (int g = 0; g <= int'(gap); g++) begin
        if (rmode == 0 && g == 0) restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        if (rmode == 0 && g == 0) m_pend = 1'b1;
        model_expect(S_R, S_H, S_BF, S_BC, eph, emk, evs);
        n_tests++;
        if ({phase, char_mask, text_visible, loop_done} !== {eph, emk, evs, 1'b0}) begin
          n_fail++;
          $display("FAIL rand_idle_it%0d: got ph=%0d mask=%h vis=%b ld=%b, want ph=%0d mask=%h vis=%b ld=0",
                   it, phase, char_mask, text_visible, loop_done, eph, emk, evs);
        end
      end
      frame_start = 1'b1;
      if (rmode == 1) restart = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      restart     = 1'b0;
      model_tick(rmode == 1, S_R, S_H, S_BF, S_BC, S_OF);
      model_expect(S_R, S_H, S_BF, S_BC, eph, emk, evs);
      n_tests++;
      if ({phase, char_mask, text_visible, loop_done} !== {eph, emk, evs, m_ld}) begin
        n_fail++;
        $display("FAIL rand_tick_it%0d: got ph=%0d mask=%h vis=%b ld=%b, want ph=%0d mask=%h vis=%b ld=%b",
                 it, phase, char_mask, text_visible, loop_done, eph, emk, evs, m_ld);
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; enable = 1'b0; restart = 1'b0;
    m_idle = 1'b1; m_pend = 1'b0; m_ld = 1'b0; m_p = 0;
    test_reset();
    test_sequence();
    test_long_strobe();
    test_enable_drop();
    test_restart();
    test_reset_collision();
    test_bounds();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
